// File: rtl/ga23_pkg.sv
// Shared GA23 definitions: palette word layout, CPU read FSM states, colour expansion.
`timescale 1ns/1ps
package ga23_pkg;
    localparam logic [7:0]  PAL_IO_BANK = 8'hA0;
    localparam int unsigned COLOR_W     = 11;
    localparam int unsigned PAL_AW      = 12;
    localparam int unsigned PAL_DW      = 16;

    typedef struct packed {
        logic       unused;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } pal_word_t;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_RD   = 2'd1,
        CPU_DONE = 2'd2
    } cpu_state_t;

    // Replicate the top bits so 5'h1F maps to 8'hFF and 5'h00 to 8'h00.
    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction
endpackage

// File: rtl/palette_dpram.sv
// 4096x16 true dual-port palette RAM: port A video read, port B CPU read/write, both synchronous.
`timescale 1ns/1ps
module palette_dpram
    import ga23_pkg::*;
(
    input  logic              clk,
    input  logic              en_a,
    input  logic [PAL_AW-1:0] addr_a,
    output logic [PAL_DW-1:0] q_a,
    input  logic              we_b,
    input  logic [PAL_AW-1:0] addr_b,
    input  logic [PAL_DW-1:0] d_b,
    output logic [PAL_DW-1:0] q_b
);
    localparam int unsigned DEPTH = 1 << PAL_AW;

    logic [PAL_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a) begin
            q_a <= mem[addr_a];
        end
    end

    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= d_b;
        end
        q_b <= mem[addr_b];
    end
endmodule

// File: rtl/ga23_palette_mixer.sv
// GA23 pixel back end: tile/sprite mix, banked palette lookup, RGB expansion and CPU palette access.
`timescale 1ns/1ps
module ga23_palette_mixer
    import ga23_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [COLOR_W-1:0] tile_color,
    input  logic               tile_prio,
    input  logic [COLOR_W-1:0] spr_color,
    input  logic               hblank_in,
    input  logic               vblank_in,
    input  logic               pal_cs,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic               io_wr,
    input  logic [15:0]        addr,
    input  logic [15:0]        cpu_din,
    output logic [15:0]        cpu_dout,
    output logic               busy,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hblank,
    output logic               vblank
);
    logic [COLOR_W-1:0] s0_tile;
    logic [COLOR_W-1:0] s0_spr;
    logic               s0_prio;
    logic               s0_hb;
    logic               s0_vb;
    logic [LATENCY-1:0] hb_pipe;
    logic [LATENCY-1:0] vb_pipe;
    logic [PAL_AW-1:0]  s1_idx;
    logic [PAL_DW-1:0]  pix_word;
    logic [PAL_DW-1:0]  cpu_q;
    pal_word_t          pix;
    logic [COLOR_W-1:0] sel_c;

    logic               pal_bank;
    cpu_state_t         state;
    logic [PAL_AW-1:0]  rd_addr;
    logic               cpu_we_c;
    logic [PAL_AW-1:0]  cpu_addr_c;
    logic               unused_bits;

    assign pix         = pal_word_t'(pix_word);
    assign hblank      = hb_pipe[LATENCY-1];
    assign vblank      = vb_pipe[LATENCY-1];
    assign unused_bits = ^{addr[15:12], pix.unused};

    // Opaque priority tile wins, then opaque sprite, else the (transparent) tile index.
    always_comb begin
        sel_c = s0_tile;
        if (s0_prio && (s0_tile[3:0] != 4'd0)) begin
            sel_c = s0_tile;
        end else if (s0_spr[3:0] != 4'd0) begin
            sel_c = s0_spr;
        end
    end

    // Pixel pipeline; S2 is the palette RAM's own read register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_tile <= '0;
            s0_spr  <= '0;
            s0_prio <= 1'b0;
            s0_hb   <= 1'b1;
            s0_vb   <= 1'b1;
            hb_pipe <= '1;
            vb_pipe <= '1;
            s1_idx  <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else if (ce) begin
            s0_tile <= tile_color;
            s0_spr  <= spr_color;
            s0_prio <= tile_prio;
            s0_hb   <= hblank_in;
            s0_vb   <= vblank_in;
            hb_pipe <= {hb_pipe[LATENCY-2:0], s0_hb};
            vb_pipe <= {vb_pipe[LATENCY-2:0], s0_vb};
            s1_idx  <= {pal_bank, sel_c};
            if (hb_pipe[LATENCY-2] || vb_pipe[LATENCY-2]) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end else begin
                red   <= expand5to8(pix.r);
                green <= expand5to8(pix.g);
                blue  <= expand5to8(pix.b);
            end
        end
    end

    // Writes go straight to port B; a read holds its latched address on port B during RD.
    assign cpu_we_c   = pal_cs && mem_wr && (state == CPU_IDLE);
    assign cpu_addr_c = (state == CPU_RD) ? rd_addr : {pal_bank, addr[11:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CPU_IDLE;
            busy     <= 1'b0;
            cpu_dout <= '0;
            rd_addr  <= '0;
            pal_bank <= 1'b0;
        end else begin
            if (io_wr && (addr[7:0] == PAL_IO_BANK)) begin
                pal_bank <= cpu_din[1];
            end
            case (state)
                CPU_IDLE: begin
                    if (pal_cs && mem_rd && !mem_wr) begin
                        state   <= CPU_RD;
                        busy    <= 1'b1;
                        rd_addr <= {pal_bank, addr[11:1]};
                    end
                end
                CPU_RD: begin
                    state <= CPU_DONE;
                end
                CPU_DONE: begin
                    state    <= CPU_IDLE;
                    busy     <= 1'b0;
                    cpu_dout <= cpu_q;
                end
                default: begin
                    state <= CPU_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    palette_dpram u_ram (
        .clk    (clk),
        .en_a   (ce),
        .addr_a (s1_idx),
        .q_a    (pix_word),
        .we_b   (cpu_we_c),
        .addr_b (cpu_addr_c),
        .d_b    (cpu_din),
        .q_b    (cpu_q)
    );
endmodule

// File: tb/tb_ga23_palette_mixer.sv
// Bench for ga23_palette_mixer: directed palette scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_ga23_palette_mixer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b0;
    logic [10:0] tile_color = '0;
    logic        tile_prio = 1'b0;
    logic [10:0] spr_color = '0;
    logic        hblank_in = 1'b0;
    logic        vblank_in = 1'b0;
    logic        pal_cs = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        busy;
    logic [7:0]  red, green, blue;
    logic        hblank, vblank;

    always #5 clk = ~clk;

    ga23_palette_mixer dut (
        .clk(clk), .reset(reset), .ce(ce),
        .tile_color(tile_color), .tile_prio(tile_prio), .spr_color(spr_color),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .pal_cs(pal_cs), .mem_rd(mem_rd), .mem_wr(mem_wr), .io_wr(io_wr),
        .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
        .red(red), .green(green), .blue(blue), .hblank(hblank), .vblank(vblank)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each ce tick pushes a pixel record; age 1 gets its bank, age 2 its palette word, age 3 is shown.
    typedef struct {
        logic [10:0] tc;
        logic        tp;
        logic [10:0] sc;
        logic        hb;
        logic        vb;
        logic [11:0] idx;
        logic [15:0] word;
    } pix_t;

    pix_t        pq[$];
    logic [15:0] mem_m [4096];
    logic        bank_m;
    int          rd_cnt;
    logic [15:0] rd_val;
    logic [15:0] exp_dout;
    logic [7:0]  exp_r, exp_g, exp_b;
    logic        exp_hb, exp_vb;

    function automatic logic [10:0] pick(input pix_t p);
        if (p.tp && p.tc[3:0] != 4'd0) return p.tc;
        if (p.sc[3:0] != 4'd0) return p.sc;
        return p.tc;
    endfunction

    function automatic logic [7:0] ch8(input logic [15:0] w, input int sh);
        int c;
        c = int'((w >> sh) & 16'h1F);
        return 8'((c << 3) | (c >> 2));
    endfunction

    task automatic model_reset();
        pix_t b;
        b.tc = '0; b.tp = 1'b0; b.sc = '0; b.hb = 1'b1; b.vb = 1'b1; b.idx = '0; b.word = '0;
        pq.delete();
        repeat (3) pq.push_front(b);
        bank_m = 1'b0; rd_cnt = 0; rd_val = '0; exp_dout = '0;
        exp_r = '0; exp_g = '0; exp_b = '0; exp_hb = 1'b1; exp_vb = 1'b1;
    endtask

    task automatic model_edge();
        if (ce) begin
            pix_t p;
            pix_t t;
            p.tc = tile_color; p.tp = tile_prio; p.sc = spr_color;
            p.hb = hblank_in; p.vb = vblank_in; p.idx = '0; p.word = '0;
            pq.push_front(p);
            t = pq[1]; t.idx = {bank_m, pick(t)}; pq[1] = t;
            t = pq[2]; t.word = mem_m[t.idx]; pq[2] = t;
            p = pq.pop_back();
            if (p.hb || p.vb) begin
                exp_r = '0; exp_g = '0; exp_b = '0;
            end else begin
                exp_r = ch8(p.word, 0); exp_g = ch8(p.word, 5); exp_b = ch8(p.word, 10);
            end
            exp_hb = p.hb; exp_vb = p.vb;
        end
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) exp_dout = rd_val;
        end else if (pal_cs && mem_wr) begin
            mem_m[{bank_m, addr[11:1]}] = cpu_din;
        end else if (pal_cs && mem_rd) begin
            rd_cnt = 2;
            rd_val = mem_m[{bank_m, addr[11:1]}];
        end
        if (io_wr && addr[7:0] == 8'hA0) bank_m = cpu_din[1];
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("red", 16'(red), 16'(exp_r));
        check("green", 16'(green), 16'(exp_g));
        check("blue", 16'(blue), 16'(exp_b));
        check("hblank", 16'(hblank), 16'(exp_hb));
        check("vblank", 16'(vblank), 16'(exp_vb));
        check("busy", 16'(busy), 16'(rd_cnt > 0));
        check("cpu_dout", cpu_dout, exp_dout);
    endtask

    // One clk: the model follows the edge, outputs are compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        pal_cs = 1'b1; mem_wr = 1'b1; addr = a; cpu_din = d;
        cycle();
        pal_cs = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic io_write(input logic [15:0] d);
        io_wr = 1'b1; addr = 16'h00A0; cpu_din = d;
        cycle();
        io_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output int nbusy);
        pal_cs = 1'b1; mem_rd = 1'b1; addr = a;
        cycle();
        pal_cs = 1'b0; mem_rd = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 10) begin
            nbusy++;
            cycle();
        end
    endtask

    task automatic pixel(input logic [10:0] tc, input logic tp, input logic [10:0] sc,
                         input logic hb, input logic vb, input int n);
        tile_color = tc; tile_prio = tp; spr_color = sc; hblank_in = hb; vblank_in = vb;
        ce = 1'b1;
        repeat (n) cycle();
        ce = 1'b0;
    endtask

    task automatic check_rgb(input string name, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        check({name, "_r"}, 16'(red), 16'(r));
        check({name, "_g"}, 16'(green), 16'(g));
        check({name, "_b"}, 16'(blue), 16'(b));
    endtask

    function automatic logic [10:0] rand_color();
        logic [10:0] c;
        c = 11'($urandom);
        if ($urandom_range(3, 0) == 0) c[3:0] = 4'd0;
        return c;
    endfunction

    initial begin
        int nb;
        int r;
        logic [7:0] hr, hg, hbl;

        #1 reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_red", 16'(red), 16'h0);
        check("rst_hblank", 16'(hblank), 16'h1);
        check("rst_vblank", 16'(vblank), 16'h1);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_cpu_dout", cpu_dout, 16'h0);

        // Give every palette word a known value in both banks.
        for (int i = 0; i < 2048; i++) cpu_write(16'(i << 1), 16'($urandom));
        io_write(16'h0002);
        for (int i = 0; i < 2048; i++) cpu_write(16'(i << 1), 16'($urandom));
        io_write(16'h0000);

        cpu_write(16'h000A, 16'h7FFF);
        cpu_read(16'h000A, nb);
        check("rd_busy_cycles", 16'(nb), 16'd2);
        check("rd_data", cpu_dout, 16'h7FFF);

        cpu_write(16'h0026, 16'h03E0);
        pixel(11'h005, 1'b1, 11'h013, 1'b0, 1'b0, 4);
        check_rgb("tile_over_spr", 8'hFF, 8'hFF, 8'hFF);
        pixel(11'h005, 1'b0, 11'h013, 1'b0, 1'b0, 4);
        check_rgb("spr_over_tile", 8'h00, 8'hFF, 8'h00);

        cpu_write(16'h0020, 16'h001F);
        pixel(11'h010, 1'b0, 11'h020, 1'b0, 1'b0, 4);
        check_rgb("both_transparent", 8'hFF, 8'h00, 8'h00);

        io_write(16'h0002);
        cpu_write(16'h000A, 16'h7C00);
        pixel(11'h005, 1'b1, 11'h000, 1'b0, 1'b0, 4);
        check_rgb("bank1", 8'h00, 8'h00, 8'hFF);

        // Inputs change while ce is low: the output must not move.
        hr = red; hg = green; hbl = blue;
        tile_color = 11'h013; hblank_in = 1'b1;
        repeat (5) cycle();
        check_rgb("ce_hold", 8'h00, 8'h00, 8'hFF);
        check("ce_hold_hblank", 16'(hblank), 16'h0);
        check("ce_hold_same_r", 16'(red), 16'(hr));
        hblank_in = 1'b0;

        // Asynchronous reset while the read FSM sits in RD.
        pal_cs = 1'b1; mem_rd = 1'b1; addr = 16'h000A;
        @(posedge clk);
        model_edge();
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 16'(busy), 16'h0);
        check("arst_cpu_dout", cpu_dout, 16'h0);
        check("arst_hblank", 16'(hblank), 16'h1);
        check("arst_vblank", 16'(vblank), 16'h1);
        check("arst_blue", 16'(blue), 16'h0);
        model_reset();
        pal_cs = 1'b0; mem_rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycle();

        pixel(11'h005, 1'b1, 11'h000, 1'b1, 1'b0, 4);
        check_rgb("hblank_gate", 8'h00, 8'h00, 8'h00);
        check("hblank_out", 16'(hblank), 16'h1);
        pixel(11'h005, 1'b1, 11'h000, 1'b0, 1'b0, 4);
        check_rgb("after_reset_bank0", 8'hFF, 8'hFF, 8'hFF);

        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom_range(1, 0) == 1);
            tile_color = rand_color();
            spr_color = rand_color();
            tile_prio = 1'($urandom_range(1, 0));
            hblank_in = ($urandom_range(9, 0) == 0);
            vblank_in = ($urandom_range(9, 0) == 0);
            pal_cs = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; io_wr = 1'b0;
            addr = 16'($urandom);
            cpu_din = 16'($urandom);
            r = int'($urandom_range(99, 0));
            if (rd_cnt == 0) begin
                if (r < 6 && !ce) begin
                    pal_cs = 1'b1; mem_wr = 1'b1; mem_rd = (r == 0);
                end else if (r < 10) begin
                    pal_cs = (r != 9); mem_rd = 1'b1;
                end else if (r < 12) begin
                    io_wr = 1'b1; addr[7:0] = 8'hA0;
                end else if (r < 14) begin
                    io_wr = 1'b1;
                end
            end else if (r < 8) begin
                pal_cs = 1'b1; mem_wr = r[0]; mem_rd = ~r[0];
            end
            cycle();
        end
        pal_cs = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; io_wr = 1'b0; ce = 1'b0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ga23_palette_mixer.md
# ga23_palette_mixer

Pixel back end downstream of the GA23 tilemap generator. Each pixel-clock tick it merges the tilemap pixel (`color_out`/`prio_out`) with the sprite pixel from the sprite generator. It looks the winning index up in a banked 4096×16 palette RAM and emits 8-bit RGB with matching delayed blanking. It also gives the CPU read/write access to the palette RAM and a bank-select I/O register.

## Interface
Parameters:
- `LATENCY`, 3: pixel ticks from input pixel to RGB output. Fixed; exposed for downstream alignment only.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `ce`  in  1  pixel clock enable; same enable as GA23
- `tile_color`  in  11  tilemap palette index; `[3:0]==0` means transparent
- `tile_prio`  in  1  tilemap pixel over sprites
- `spr_color`  in  11  sprite palette index; `[3:0]==0` means transparent
- `hblank_in`, `vblank_in`  in  1 each  blanking aligned with the pixel inputs
- `pal_cs`  in  1  CPU palette window select
- `mem_rd`, `mem_wr`  in  1 each  CPU strobes, one `clk` wide
- `io_wr`  in  1  CPU I/O write strobe
- `addr`  in  16  CPU byte address
- `cpu_din`  in  16  CPU write data
- `cpu_dout`  out  16  CPU read data
- `busy`  out  1  CPU access in progress
- `red`, `green`, `blue`  out  8 each  pixel colour
- `hblank`, `vblank`  out  1 each  blanking delayed by `LATENCY` ticks

## Operation
- **Bank register.** `pal_bank` (1 bit) is written by `io_wr` with `addr[7:0]=='hA0`, taking `cpu_din[1]`. Reset value 0.
- **Mix.** Applied to the registered inputs each `ce`:
  - `sel = tile_color` if `tile_prio` and `tile_color[3:0]!=0`;
  - else `sel = spr_color` if `spr_color[3:0]!=0`;
  - else `sel = tile_color`.
- **Lookup index.** `{pal_bank, sel}` (12 bits).
- **Palette word layout.**
  - bits `[4:0]` = R, `[9:5]` = G, `[14:10]` = B. Bit 15 is ignored.
  - Each 5-bit channel `c` expands to 8 bits as `{c, c[4:2]}`.
- **Blanking.** If the delayed `hblank` or `vblank` is 1, RGB outputs 0.
- **CPU access.** Word address is `{pal_bank, addr[11:1]}`. `addr[15:12]` is ignored; decoding is done by `pal_cs`.
  - Write (`pal_cs & mem_wr`): RAM port B written in that same `clk`. `busy` stays 0.
  - Read (`pal_cs & mem_rd`): FSM runs IDLE → RD → DONE → IDLE, one state per `clk`, independent of `ce`.
    - RD issues the port B address.
    - DONE latches `cpu_dout`.
    - `busy` = 1 in RD and DONE.
  - `mem_rd` and `mem_wr` both set: treated as a write; no read FSM.
  - New strobes while `busy`: ignored.
- **Simultaneous same-address access.** Video port A and CPU port B may hit the same word. Port A returns either old or new data; both are acceptable. Writes never stall video.

## Timing
- **Pixel pipeline** (advances only on `ce`):
  - S0: register inputs and blanking.
  - S1: mix; register the 12-bit index.
  - S2: synchronous RAM read.
  - S3: expand and register RGB plus delayed blanking.
- **Latency.** Input sampled at tick n appears on the outputs after tick n+3.
- **Held state.** With `ce=0` all pipeline registers hold.
- **Bank change.** Takes effect on the first S1 after the write. Pixels already past S1 keep the old bank.
- **Reset values.**
  - `red`/`green`/`blue` = 0.
  - `hblank` = `vblank` = 1.
  - `cpu_dout` = 0, `busy` = 0, FSM = IDLE, `pal_bank` = 0.
  - Pipeline registers cleared to index 0 with blank asserted.
  - RAM contents are not reset.
- **Reset mid-read.** FSM returns to IDLE and `busy` drops immediately (asynchronous). `cpu_dout` = 0.

## Structure
- Shared package `ga23_pkg`:
  - `PAL_IO_BANK` = 8'hA0;
  - `pal_word_t` packed struct {unused, b, g, r};
  - `expand5to8` function.
- Sub-module `palette_dpram`: 4096×16 true dual-port RAM, both ports synchronous.
  - Port A: video, read-only.
  - Port B: CPU, read/write.
  - No reset. Both ports on `clk`.

## Test plan
- **Write then read.** CPU writes 16'h7FFF to palette word 5 (bank 0), then reads it back.
  - `busy` is high for exactly 2 clocks.
  - `cpu_dout` = 16'h7FFF.
- **Tile over sprite.** `tile_color`=11'h005, `tile_prio`=1, `spr_color`=11'h013, blanks 0.
  - Output after 3 `ce` ticks is RGB FF/FF/FF.
  - With `tile_prio`=0, output shows entry 0x013.
- **Transparency.** `tile_color`=11'h010, `spr_color`=11'h020 selects `tile_color`, i.e. entry 0x010.
  - Load entry 0x010 with 16'h001F → RGB = FF/00/00.
- **Bank switch.** I/O write `cpu_din`=2 to 'hA0; write entry 0x805 = 16'h7C00.
  - Pixel index 0x005 yields blue FF, red/green 00.
- **Blanking.** `hblank_in`=1 yields RGB 0 and `hblank`=1 three ticks later. `ce` held low for 5 clocks → outputs unchanged.
- **Async reset during a read.** Assert reset during state RD.
  - `busy`=0, `cpu_dout`=0, `hblank`=`vblank`=1 without a clock edge.
